// File: rtl/window_decimator_pkg.sv
// Shared constants and helpers for the window decimator.
//   MODE_PICK / MODE_MEAN : values of i_mode.
//   DEFAULT_*             : default widths for the parameterised modules.
//   clamp_log2()          : limits a requested window exponent to the supported maximum.
package window_decimator_pkg;

  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_MEAN = 1'b1;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_MAX_LOG2   = 4;
  localparam int unsigned DEFAULT_LOG2_WIDTH = 3;

  function automatic int unsigned clamp_log2(input int unsigned req,
                                             input int unsigned max_log2);
    return (req > max_log2) ? max_log2 : req;
  endfunction

endpackage

// File: rtl/window_decimator_phase_ctr.sv
// Window sequencing for the decimator: tracks the position inside the current window and
// the window exponent / mode latched at its first sample.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   ce                   : input sample strobe
//   log2_factor, mode    : live window exponent request and mode
//   window_start/_end    : current strobe opens / closes a window
//   k_eff, mode_eff      : exponent and mode that apply to the current strobe
//   phase, k_active,
//   mode_active          : register copies, only with WINDOW_DECIMATOR_DEBUG_EN
module window_decimator_phase_ctr
  import window_decimator_pkg::*;
#(
  parameter int unsigned MAX_LOG2   = DEFAULT_MAX_LOG2,
  parameter int unsigned LOG2_WIDTH = DEFAULT_LOG2_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic [LOG2_WIDTH-1:0] log2_factor,
  input  logic                  mode,
  output logic                  window_start,
  output logic                  window_end,
  output logic [LOG2_WIDTH-1:0] k_eff,
  output logic                  mode_eff
`ifdef WINDOW_DECIMATOR_DEBUG_EN
  ,
  output logic [MAX_LOG2-1:0]   phase,
  output logic [LOG2_WIDTH-1:0] k_active,
  output logic                  mode_active
`endif
);

  logic [MAX_LOG2-1:0]   phase_q, phase_d;
  logic [LOG2_WIDTH-1:0] k_active_q, k_active_d;
  logic                  mode_active_q, mode_active_d;
  logic [LOG2_WIDTH-1:0] k_clamped;
  logic [MAX_LOG2-1:0]   last_phase;

  assign k_clamped = LOG2_WIDTH'(clamp_log2(32'(log2_factor), MAX_LOG2));

  always_comb begin
    window_start  = ce && (phase_q == '0);
    // The opening sample uses the live request; later samples use the latched one.
    k_eff         = window_start ? k_clamped : k_active_q;
    mode_eff      = window_start ? mode : mode_active_q;
    last_phase    = MAX_LOG2'((32'd1 << k_eff) - 32'd1);
    window_end    = ce && (phase_q == last_phase);

    phase_d       = phase_q;
    k_active_d    = k_active_q;
    mode_active_d = mode_active_q;
    if (ce) begin
      phase_d = window_end ? '0 : phase_q + MAX_LOG2'(1);
    end
    if (window_start) begin
      k_active_d    = k_clamped;
      mode_active_d = mode;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= '0;
      k_active_q    <= '0;
      mode_active_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      k_active_q    <= k_active_d;
      mode_active_q <= mode_active_d;
    end
  end

`ifdef WINDOW_DECIMATOR_DEBUG_EN
  assign phase       = phase_q;
  assign k_active    = k_active_q;
  assign mode_active = mode_active_q;
`endif

endmodule

// File: rtl/window_decimator.sv
// Rate reducer: emits one sample per window of 2^k strobed input samples, either the last
// sample of the window (pick) or the floor mean of the window (mean).
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_ce, data_in  : input strobe and signed sample
//   i_log2_factor  : requested window exponent (clamped to MAX_LOG2)
//   i_mode         : 0 pick, 1 mean
//   data_out, o_ce : registered decimated sample and one-cycle strobe
// Optional build macro WINDOW_DECIMATOR_DEBUG_EN exposes o_phase, o_acc, o_k_active and
// o_mode_active as direct copies of the internal registers.
module window_decimator
  import window_decimator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned MAX_LOG2   = DEFAULT_MAX_LOG2,
  parameter int unsigned LOG2_WIDTH = DEFAULT_LOG2_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_ce,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic [LOG2_WIDTH-1:0]        i_log2_factor,
  input  logic                         i_mode,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         o_ce
`ifdef WINDOW_DECIMATOR_DEBUG_EN
  ,
  output logic [MAX_LOG2-1:0]                   o_phase,
  output logic signed [DATA_WIDTH+MAX_LOG2-1:0] o_acc,
  output logic [LOG2_WIDTH-1:0]                 o_k_active,
  output logic                                  o_mode_active
`endif
);

  localparam int unsigned AccWidth = DATA_WIDTH + MAX_LOG2;

  logic                         window_start;
  logic                         window_end;
  logic [LOG2_WIDTH-1:0]        k_eff;
  logic                         mode_eff;

  logic signed [AccWidth-1:0]   acc_q, acc_d;
  logic signed [AccWidth-1:0]   data_ext;
  logic signed [AccWidth-1:0]   sum;
  logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                         o_ce_q, o_ce_d;

  window_decimator_phase_ctr #(
    .MAX_LOG2   (MAX_LOG2),
    .LOG2_WIDTH (LOG2_WIDTH)
  ) u_phase_ctr (
    .clk          (clk),
    .reset_n      (reset_n),
    .ce           (i_ce),
    .log2_factor  (i_log2_factor),
    .mode         (i_mode),
    .window_start (window_start),
    .window_end   (window_end),
    .k_eff        (k_eff),
    .mode_eff     (mode_eff)
`ifdef WINDOW_DECIMATOR_DEBUG_EN
    ,
    .phase        (o_phase),
    .k_active     (o_k_active),
    .mode_active  (o_mode_active)
`endif
  );

  always_comb begin
    data_ext   = {{MAX_LOG2{data_in[DATA_WIDTH-1]}}, data_in};
    // A window always opens from an empty accumulator, whatever acc_q holds.
    sum        = (window_start ? '0 : acc_q) + data_ext;
    acc_d      = acc_q;
    data_out_d = data_out_q;
    o_ce_d     = window_end;

    if (i_ce) begin
      acc_d = window_end ? '0 : sum;
    end
    if (window_end) begin
      unique case (mode_eff)
        MODE_PICK: data_out_d = data_in;
        // A mean of in-range samples is in range, so truncation loses nothing.
        MODE_MEAN: data_out_d = DATA_WIDTH'(sum >>> k_eff);
        default:   data_out_d = data_out_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q      <= '0;
      data_out_q <= '0;
      o_ce_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
      o_ce_q     <= o_ce_d;
    end
  end

  assign data_out = data_out_q;
  assign o_ce     = o_ce_q;

`ifdef WINDOW_DECIMATOR_DEBUG_EN
  assign o_acc = acc_q;
`endif

endmodule

// File: tb/tb_window_decimator.sv
// Directed self-checking bench for window_decimator (default parameters).
module tb_window_decimator;

  logic              clk;
  logic              reset_n;
  logic              i_ce;
  logic signed [7:0] data_in;
  logic [2:0]        i_log2_factor;
  logic              i_mode;
  logic signed [7:0] data_out;
  logic              o_ce;

  int passed;
  int total;

  // Outputs seen at the most recent negedge, i.e. the result of the previously driven input.
  logic              obs_ce;
  logic signed [7:0] obs_data;

  window_decimator dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_ce          (i_ce),
    .data_in       (data_in),
    .i_log2_factor (i_log2_factor),
    .i_mode        (i_mode),
    .data_out      (data_out),
    .o_ce          (o_ce)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sample outputs at the negedge, then drive the next input for the coming posedge.
  task automatic cycle(input logic ce, input logic signed [7:0] v);
    @(negedge clk);
    obs_ce   = o_ce;
    obs_data = data_out;
    i_ce     = ce;
    data_in  = v;
  endtask

  task automatic test_reset();
    reset_n       = 1'b1;
    i_ce          = 1'b0;
    data_in       = '0;
    i_log2_factor = 3'd0;
    i_mode        = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (data_out !== 8'sd0) $display("FAIL reset_data: got %0d want 0", data_out);
    else passed++;
    total++;
    if (o_ce !== 1'b0) $display("FAIL reset_ce: got %b want 0", o_ce);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;

    // Complete one k=1 mean window, then leave a partial one behind.
    i_log2_factor = 3'd1;
    i_mode        = 1'b1;
    cycle(1'b1, 8'sd40);
    cycle(1'b1, 8'sd40);
    cycle(1'b1, 8'sd99);
    total++;
    if (obs_ce !== 1'b1 || obs_data !== 8'sd40)
      $display("FAIL pre_reset_window: got ce=%b data=%0d want ce=1 data=40", obs_ce, obs_data);
    else passed++;
    cycle(1'b0, 8'sd0);

    // Asynchronous assertion well away from any clock edge.
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (data_out !== 8'sd0) $display("FAIL async_reset_data: got %0d want 0", data_out);
    else passed++;
    total++;
    if (o_ce !== 1'b0) $display("FAIL async_reset_ce: got %b want 0", o_ce);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;

    cycle(1'b1, 8'sd4);
    cycle(1'b1, 8'sd6);
    cycle(1'b0, 8'sd0);
    total++;
    if (obs_ce !== 1'b1 || obs_data !== 8'sd5)
      $display("FAIL post_reset_mean: got ce=%b data=%0d want ce=1 data=5", obs_ce, obs_data);
    else passed++;
  endtask

  task automatic test_k0();
    int vals[3];
    vals = '{10, -20, 30};
    for (int m = 0; m < 2; m++) begin
      i_log2_factor = 3'd0;
      i_mode        = 1'(m);
      cycle(1'b0, 8'sd0);
      for (int i = 0; i < 4; i++) begin
        if (i < 3) cycle(1'b1, 8'(vals[i]));
        else cycle(1'b0, 8'sd0);
        if (i == 0) begin
          total++;
          if (obs_ce !== 1'b0) $display("FAIL k0_idle_ce mode=%0d: got %b want 0", m, obs_ce);
          else passed++;
        end else begin
          total++;
          if (obs_ce !== 1'b1 || obs_data !== 8'(vals[i-1]))
            $display("FAIL k0_pass mode=%0d idx=%0d: got ce=%b data=%0d want ce=1 data=%0d",
                     m, i - 1, obs_ce, obs_data, vals[i-1]);
          else passed++;
        end
      end
      cycle(1'b0, 8'sd0);
      total++;
      if (obs_ce !== 1'b0) $display("FAIL k0_tail_ce mode=%0d: got %b want 0", m, obs_ce);
      else passed++;
    end
  endtask

  task automatic test_pick_k2();
    int vals[8];
    int pulses;
    int got[$];
    vals = '{10, -20, 30, -40, 50, 0, 100, -127};
    pulses = 0;
    i_log2_factor = 3'd2;
    i_mode        = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) cycle(1'b1, 8'(vals[i]));
      else cycle(1'b0, 8'sd0);
      if (obs_ce === 1'b1) begin
        pulses++;
        got.push_back(int'(obs_data));
      end
    end
    total++;
    if (pulses != 2) $display("FAIL pick_k2_count: got %0d want 2", pulses);
    else passed++;
    if (pulses == 2) begin
      total++;
      if (got[0] != -40 || got[1] != -127)
        $display("FAIL pick_k2_values: got %0d,%0d want -40,-127", got[0], got[1]);
      else passed++;
    end
  endtask

  task automatic test_mean_rounding();
    int ks[4];
    int samp[4][4];
    int expv[4];
    int early;
    ks   = '{2, 1, 1, 1};
    samp = '{'{10, -20, 30, -40}, '{-1, -2, 0, 0}, '{127, -60, 0, 0}, '{-128, -128, 0, 0}};
    expv = '{-5, -2, 33, -128};
    i_mode = 1'b1;
    for (int c = 0; c < 4; c++) begin
      i_log2_factor = 3'(ks[c]);
      early = 0;
      for (int j = 0; j < (1 << ks[c]); j++) begin
        cycle(1'b1, 8'(samp[c][j]));
        if (obs_ce === 1'b1) early++;
      end
      cycle(1'b0, 8'sd0);
      total++;
      if (obs_ce !== 1'b1 || early != 0)
        $display("FAIL mean_strobe case=%0d: got ce=%b early=%0d want ce=1 early=0",
                 c, obs_ce, early);
      else passed++;
      total++;
      if (obs_data !== 8'(expv[c]))
        $display("FAIL mean_value case=%0d: got %0d want %0d", c, obs_data, expv[c]);
      else passed++;
    end
  endtask

  task automatic test_mid_window_change();
    int vals[8];
    int got[$];
    int idx[$];
    vals = '{8, 12, 16, 20, 5, 7, -9, 3};
    i_log2_factor = 3'd2;
    i_mode        = 1'b1;
    cycle(1'b0, 8'sd0);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) cycle(1'b1, 8'(vals[i]));
      else cycle(1'b0, 8'sd0);
      if (obs_ce === 1'b1) begin
        got.push_back(int'(obs_data));
        idx.push_back(i - 1);
      end
      if (i == 1) begin
        @(posedge clk);
        #1;
        i_log2_factor = 3'd1;
        i_mode        = 1'b0;
      end
    end
    total++;
    if (got.size() != 3) $display("FAIL midwin_count: got %0d want 3", got.size());
    else passed++;
    if (got.size() == 3) begin
      total++;
      if (idx[0] != 3 || idx[1] != 5 || idx[2] != 7)
        $display("FAIL midwin_positions: got %0d,%0d,%0d want 3,5,7", idx[0], idx[1], idx[2]);
      else passed++;
      total++;
      if (got[0] != 14 || got[1] != 7 || got[2] != 3)
        $display("FAIL midwin_values: got %0d,%0d,%0d want 14,7,3", got[0], got[1], got[2]);
      else passed++;
    end
  endtask

  task automatic test_clamp_gaps();
    int pulses;
    int first_idx;
    int bad_vals;
    pulses    = 0;
    first_idx = -1;
    bad_vals  = 0;
    i_log2_factor = 3'd7;
    i_mode        = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 8'sd100);
      for (int g = 0; g < 2; g++) begin
        cycle(1'b0, 8'sd0);
        if (obs_ce === 1'b1) begin
          pulses++;
          if (first_idx < 0) first_idx = i;
          if (obs_data !== 8'sd100) bad_vals++;
        end
      end
    end
    cycle(1'b0, 8'sd0);
    if (obs_ce === 1'b1) pulses++;
    total++;
    if (pulses != 2) $display("FAIL clamp_count: got %0d want 2", pulses);
    else passed++;
    total++;
    if (first_idx != 15) $display("FAIL clamp_first_pulse: got sample %0d want 15", first_idx);
    else passed++;
    total++;
    if (bad_vals != 0) $display("FAIL clamp_mean_value: got %0d wrong values want 0", bad_vals);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_k0();
    test_pick_k2();
    test_mean_rounding();
    test_mid_window_change();
    test_clamp_gaps();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
